// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types and widths for the fp32 normalise/round/pack back end
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 2**(EXP_W-1) - 1;
  localparam int MW     = FRAC_W + 5;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef enum logic [2:0] {
    IDLE,
    NORM,
    ROUND,
    PACK,
    DONE
  } norm_state_t;

  typedef struct packed {
    logic ovf;
    logic unf;
    logic inexact;
    logic zero;
  } fp_flags_t;

endpackage

// File: rtl/fp32_normalize_pack_if.sv
// rtl/fp32_normalize_pack_if.sv - operand in / packed result out handshake bundle
interface fp32_normalize_pack_if;
  import fp_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic                 in_sign;
  logic [EXP_W+1:0]     in_exp;
  logic [MW-1:0]        in_mant;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_data;
  logic [3:0]           out_flags;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, out_ready,
    input  in_ready, out_valid, out_data, out_flags
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, out_ready,
    output in_ready, out_valid, out_data, out_flags
  );

endinterface

// File: rtl/fp_round_rne.sv
// rtl/fp_round_rne.sv - combinational round-to-nearest-even on the extended mantissa
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [MW-1:0] mant_i,
  output logic [MW-1:0] mant_o,
  output logic          carry_o,
  output logic          inexact_o
);

  logic        round_up;
  logic [24:0] sum;

  // G at [2]; round up on G with any sticky bits, or on an exact tie with an odd LSB.
  assign round_up  = mant_i[2] & (mant_i[1] | mant_i[0] | mant_i[3]);
  assign inexact_o = mant_i[2] | mant_i[1] | mant_i[0];
  assign sum       = mant_i[MW-1:3] + 25'(round_up);
  assign carry_o   = sum[24];

  always_comb begin
    mant_o = {sum, 3'b000};
    if (carry_o) begin
      mant_o = {1'b0, sum[24:1], 3'b000};
    end
  end

endmodule

// File: rtl/fp32_normalize_pack.sv
// rtl/fp32_normalize_pack.sv - iterative normalise, RNE round and binary32 pack FSM
module fp32_normalize_pack
  import fp_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  fp32_normalize_pack_if.slave   bus
);

  localparam logic signed [EXP_W+1:0] EXP_ONE  = (EXP_W+2)'(1);
  localparam logic signed [EXP_W+1:0] EXP_ZERO = '0;
  localparam logic signed [EXP_W+1:0] EXP_MAX  = (EXP_W+2)'(2*BIAS+1);

  norm_state_t              state_q;
  logic                     sign_q;
  logic signed [EXP_W+1:0]  exp_q;
  logic [MW-1:0]            mant_q;
  logic                     zero_q;
  logic                     inexact_q;
  logic                     in_ready_q;
  logic                     out_valid_q;
  fp32_t                    out_data_q;
  fp_flags_t                out_flags_q;

  logic [MW-1:0]            rnd_mant;
  logic                     rnd_carry;
  logic                     rnd_inexact;

  fp_round_rne u_round (
    .mant_i    (mant_q),
    .mant_o    (rnd_mant),
    .carry_o   (rnd_carry),
    .inexact_o (rnd_inexact)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_flags = out_flags_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      zero_q      <= 1'b0;
      inexact_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_flags_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            sign_q     <= bus.in_sign;
            exp_q      <= bus.in_exp;
            mant_q     <= bus.in_mant;
            zero_q     <= 1'b0;
            inexact_q  <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= NORM;
          end
        end
        NORM: begin
          if (mant_q == '0) begin
            zero_q  <= 1'b1;
            state_q <= PACK;
          end else if (mant_q[MW-1]) begin
            // Carry out of the add: shift right once, folding the lost bit into sticky.
            mant_q  <= {1'b0, mant_q[MW-1:2], mant_q[1] | mant_q[0]};
            exp_q   <= exp_q + EXP_ONE;
            state_q <= ROUND;
          end else if (mant_q[MW-2]) begin
            state_q <= ROUND;
          end else if (exp_q <= EXP_ONE) begin
            state_q <= ROUND;
          end else begin
            mant_q <= {mant_q[MW-2:0], 1'b0};
            exp_q  <= exp_q - EXP_ONE;
          end
        end
        ROUND: begin
          mant_q    <= rnd_mant;
          exp_q     <= exp_q + (EXP_W+2)'(rnd_carry);
          inexact_q <= rnd_inexact;
          state_q   <= PACK;
        end
        PACK: begin
          out_flags_q <= '0;
          if (zero_q) begin
            out_data_q       <= '{sign: sign_q, exp: 8'h00, frac: 23'h0};
            out_flags_q.zero <= 1'b1;
          end else if (exp_q >= EXP_MAX) begin
            out_data_q          <= '{sign: sign_q, exp: 8'hFF, frac: 23'h0};
            out_flags_q.ovf     <= 1'b1;
            out_flags_q.inexact <= 1'b1;
          end else if (exp_q <= EXP_ZERO || !mant_q[MW-2]) begin
            out_data_q          <= '{sign: sign_q, exp: 8'h00, frac: 23'h0};
            out_flags_q.unf     <= 1'b1;
            out_flags_q.zero    <= 1'b1;
            out_flags_q.inexact <= inexact_q;
          end else begin
            out_data_q          <= '{sign: sign_q, exp: exp_q[EXP_W-1:0], frac: mant_q[MW-3:3]};
            out_flags_q.inexact <= inexact_q;
          end
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_normalize_pack.sv
// tb/tb_fp32_normalize_pack.sv - scoreboard bench for fp32_normalize_pack
module tb_fp32_normalize_pack;
  import fp_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  flags;
    int          lat;
    int          stall;
    int          issue;
    string       name;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb_q[$];

  fp32_normalize_pack_if bus ();

  fp32_normalize_pack dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, want);
    end
  endtask

  task automatic send(input string name, input logic sgn, input logic [9:0] e, input logic [27:0] m,
                      input logic [31:0] data, input logic [3:0] flags, input int lat, input int stall);
    exp_t x;
    int   t;
    t = 0;
    @(posedge clk); #1;
    while (!bus.in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!bus.in_ready) begin
      chk({name, "_accept_timeout"}, 32'(bus.in_ready), 32'd1);
      return;
    end
    x.data = data; x.flags = flags; x.lat = lat; x.stall = stall; x.issue = cyc; x.name = name;
    sb_q.push_back(x);
    bus.in_sign  = sgn;
    bus.in_exp   = e;
    bus.in_mant  = m;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Monitor: pops the oldest expectation whenever a result is presented.
  initial begin
    exp_t x;
    logic [31:0] held;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
          bus.out_ready = 1'b1;
          @(negedge clk);
          bus.out_ready = 1'b0;
        end else begin
          x = sb_q.pop_front();
          held = bus.out_data;
          chk({x.name, "_data"}, bus.out_data, x.data);
          chk({x.name, "_flags"}, 32'(bus.out_flags), 32'(x.flags));
          chk({x.name, "_latency"}, 32'(cyc - x.issue), 32'(x.lat));
          for (int i = 0; i < x.stall; i++) begin
            @(negedge clk);
            chk({x.name, "_stall_data"}, bus.out_data, held);
            chk({x.name, "_stall_in_ready"}, 32'(bus.in_ready), 32'd0);
          end
          bus.out_ready = 1'b1;
          @(negedge clk);
          bus.out_ready = 1'b0;
          chk({x.name, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
        end
      end
    end
  end

  initial begin
    int t;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sign  = 1'b0;
    bus.in_exp   = '0;
    bus.in_mant  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready",  32'(bus.in_ready),  32'd1);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_out_data",  bus.out_data,       32'h0);
    chk("reset_out_flags", 32'(bus.out_flags), 32'd0);
    rst = 1'b0;

    //    name          sign exp      mant          data          flags    lat stall
    send("one",         1'b0, 10'd127, 28'h4000000, 32'h3F800000, 4'b0000, 4, 0);
    send("carry",       1'b0, 10'd128, 28'hC000000, 32'h40C00000, 4'b0000, 4, 0);
    send("left_norm",   1'b0, 10'd130, 28'h0800000, 32'h3F800000, 4'b0000, 7, 0);
    send("rne_up",      1'b0, 10'd127, 28'h400000C, 32'h3F800002, 4'b0010, 4, 0);
    send("rne_tie",     1'b0, 10'd127, 28'h4000004, 32'h3F800000, 4'b0010, 4, 0);
    send("rne_carry",   1'b0, 10'd127, 28'h7FFFFFC, 32'h40000000, 4'b0010, 4, 0);
    send("overflow",    1'b0, 10'd254, 28'hC000000, 32'h7F800000, 4'b1010, 4, 0);
    send("neg_zero",    1'b1, 10'd127, 28'h0000000, 32'h80000000, 4'b0001, 3, 0);
    send("underflow",   1'b0, 10'd0,   28'h4000000, 32'h00000000, 4'b0101, 4, 0);
    send("denorm_stop", 1'b0, 10'd2,   28'h0800000, 32'h00000000, 4'b0101, 5, 0);
    send("neg_two_bp",  1'b1, 10'd128, 28'h4000000, 32'hC0000000, 4'b0000, 4, 5);

    // Abort a long normalisation with reset; no result may follow.
    t = 0;
    @(posedge clk); #1;
    while (!bus.in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("abort_accept_ready", 32'(bus.in_ready), 32'd1);
    bus.in_sign = 1'b0; bus.in_exp = 10'd130; bus.in_mant = 28'h0800000; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready",  32'(bus.in_ready),  32'd1);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    repeat (12) @(posedge clk);

    send("after_abort", 1'b0, 10'd127, 28'h4000000, 32'h3F800000, 4'b0000, 4, 0);

    t = 0;
    while ((sb_q.size() != 0 || bus.out_valid || bus.out_ready) && t < 200) begin
      @(posedge clk);
      t++;
    end
    repeat (2) @(posedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
